mul_seq: RTL

//  Sequential unsigned multiplier controller that drives the combinational ALU (op_decode) directly

---
 rtl/mul_seq_pkg.sv | 17 +
 rtl/mul_seq.sv | 103 ++++++++++
 2 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier and its ALU link.
// Opcode constants, default widths and FSM state encoding.
package mul_seq_pkg;

  localparam int PREFIX_WIDTH_DEF = 2;
  localparam int INST_WIDTH_DEF   = 3;
  localparam int OP_WIDTH_DEF     = PREFIX_WIDTH_DEF + INST_WIDTH_DEF;

  localparam logic [OP_WIDTH_DEF-1:0] ALU_OP_ADD = 5'b10000;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-and-add unsigned multiplier that borrows an external
// combinational ALU for its adds; one step per clock, fixed latency.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3,
  parameter int PREFIX_WIDTH   = PREFIX_WIDTH_DEF,
  parameter int INST_WIDTH     = INST_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [BUS_WIDTH-1:0]              a,
  input  logic [BUS_WIDTH-1:0]              b,
  output logic                              busy,
  output logic                              done,
  output logic [2*BUS_WIDTH-1:0]            product,
  output logic [PREFIX_WIDTH+INST_WIDTH-1:0] alu_opcode,
  output logic [BUS_WIDTH-1:0]              alu_a,
  output logic [BUS_WIDTH-1:0]              alu_b,
  output logic                              alu_cin,
  input  logic [BUS_WIDTH-1:0]              alu_y,
  input  logic                              alu_cout
);

  localparam int W   = BUS_WIDTH;
  localparam int CW  = BUS_WIDTH_BITS;
  localparam int OPW = PREFIX_WIDTH + INST_WIDTH;

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  ms_state_e       state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MS_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      MS_IDLE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = MS_CALC;
        end
      end
      MS_CALC: begin
        // carry-out is the top bit of the partial sum; dropping it
        // corrupts large products
        hi_d  = {alu_cout, alu_y[W-1:1]};
        lo_d  = {alu_y[0], lo_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = MS_DONE;
          prod_d  = {hi_d, lo_d};
        end
      end
      MS_DONE: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != MS_IDLE);
  assign done       = (state_q == MS_DONE);
  assign product    = prod_q;
  assign alu_opcode = OPW'(ALU_OP_ADD);
  assign alu_cin    = 1'b0;
  assign alu_b      = hi_q;
  assign alu_a      = (state_q == MS_CALC && lo_q[0]) ? mcand_q : '0;

endmodule
